// File: rtl/alu_multicycle_param_if.sv
// Handshake/data bundle for alu_multicycle_param.
//   master : operand source / result consumer (drives in_valid, A, B, opcode, out_ready)
//   slave  : the ALU (drives in_ready, out_valid, result and flags)
// Flags: carry_out, overflow, zero_flag, div_by_zero accompany result under out_valid.
interface alu_multicycle_param_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero_flag;
    logic             div_by_zero;

    modport master (
        output in_valid, A, B, opcode, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero_flag, div_by_zero
    );

    modport slave (
        input  in_valid, A, B, opcode, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero_flag, div_by_zero
    );
endinterface

// File: rtl/alu_multicycle_param.sv
// Parametrised multi-cycle ALU, 16-op opcode map, WIDTH-bit operands.
// Add/logic/shift ops complete in one cycle; MUL is shift-add and DIV/MOD is a
// restoring divider, each taking WIDTH iterations, so no wide combinational
// multiplier or divider is built.
// Ports:
//   clk  - clock, posedge
//   rst  - synchronous active-high reset
//   bus  - alu_multicycle_param_if.slave: in_valid/in_ready operand handshake,
//          out_valid/out_ready result handshake, result + carry/overflow/zero/div-by-zero flags
module alu_multicycle_param #(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    alu_multicycle_param_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_MOD  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_DEC  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NAND = 4'hB;
    localparam logic [3:0] OP_NOT  = 4'hC;
    localparam logic [3:0] OP_SRL  = 4'hD;
    localparam logic [3:0] OP_SLL  = 4'hE;
    localparam logic [3:0] OP_XNOR = 4'hF;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nxt;

    // opa: MUL multiplicand (shifts left) / DIV dividend that becomes the quotient
    // opb: MUL multiplier (shifts right) / DIV divisor
    // acc: MUL partial product / DIV partial remainder
    logic [WIDTH-1:0] opa, opb, acc;
    logic [3:0]       op_q;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] result_q;
    logic             carry_q, ovf_q, zero_q, dbz_q;

    logic accept, b_zero, is_iter, start_exec, last_iter;

    assign accept     = bus.in_valid && (state == IDLE);
    assign b_zero     = (bus.B == '0);
    assign is_iter    = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV) || (bus.opcode == OP_MOD);
    // DIV/MOD by zero has a defined immediate answer, so it skips the iterative path
    assign start_exec = is_iter && !(b_zero && (bus.opcode != OP_MUL));
    assign last_iter  = (cnt == SHW'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)        state_nxt = start_exec ? EXEC : DONE;
            EXEC: if (last_iter)     state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // ---------------- single-cycle ops ----------------
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res1;
    logic             c1, v1, dbz1;

    always_comb begin
        ext  = '0;
        res1 = '0;
        c1   = 1'b0;
        v1   = 1'b0;
        dbz1 = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                ext  = {1'b0, bus.A} + {1'b0, bus.B};
                res1 = ext[WIDTH-1:0];
                c1   = ext[WIDTH];
                v1   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (res1[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                // bit WIDTH of the extended difference is the unsigned borrow
                ext  = {1'b0, bus.A} - {1'b0, bus.B};
                res1 = ext[WIDTH-1:0];
                c1   = ext[WIDTH];
                v1   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (res1[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_INC: begin
                ext  = {1'b0, bus.A} + ONE_EXT;
                res1 = ext[WIDTH-1:0];
                c1   = ext[WIDTH];
                v1   = !bus.A[WIDTH-1] && res1[WIDTH-1];
            end
            OP_DEC: begin
                ext  = {1'b0, bus.A} - ONE_EXT;
                res1 = ext[WIDTH-1:0];
                c1   = ext[WIDTH];
                v1   = bus.A[WIDTH-1] && !res1[WIDTH-1];
            end
            // only reach DONE from IDLE for these when B==0
            OP_DIV:  begin res1 = '1;    dbz1 = 1'b1; end
            OP_MOD:  begin res1 = bus.A; dbz1 = 1'b1; end
            OP_AND:  res1 = bus.A & bus.B;
            OP_OR:   res1 = bus.A | bus.B;
            OP_NOR:  res1 = ~(bus.A | bus.B);
            OP_XOR:  res1 = bus.A ^ bus.B;
            OP_NAND: res1 = ~(bus.A & bus.B);
            OP_NOT:  res1 = ~bus.A;
            OP_SRL:  res1 = bus.A >> bus.B[SHW-1:0];
            OP_SLL:  res1 = bus.A << bus.B[SHW-1:0];
            OP_XNOR: res1 = ~(bus.A ^ bus.B);
            default: res1 = '0;
        endcase
    end

    // ---------------- one iteration of MUL / DIV ----------------
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] acc_nx, opa_nx, opb_nx, fin_res;

    always_comb begin
        div_trial = {acc, opa[WIDTH-1]} - {1'b0, opb};
        acc_nx    = acc;
        opa_nx    = opa;
        opb_nx    = opb;
        if (op_q == OP_MUL) begin
            acc_nx = acc + (opb[0] ? opa : '0);
            opa_nx = opa << 1;
            opb_nx = opb >> 1;
        end else if (!div_trial[WIDTH]) begin
            // trial subtract fits: keep it, quotient bit 1
            acc_nx = div_trial[WIDTH-1:0];
            opa_nx = {opa[WIDTH-2:0], 1'b1};
        end else begin
            // restore: just shift the dividend bit in, quotient bit 0
            acc_nx = {acc[WIDTH-2:0], opa[WIDTH-1]};
            opa_nx = {opa[WIDTH-2:0], 1'b0};
        end
        fin_res = (op_q == OP_DIV) ? opa_nx : acc_nx;
    end

    // ---------------- datapath registers ----------------
    // Operand/iteration registers load only on an accepted iterative op and step
    // only in EXEC, so nothing toggles while idle or waiting for out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q <= bus.opcode;
                    if (start_exec) begin
                        opa <= bus.A;
                        opb <= bus.B;
                        acc <= '0;
                        cnt <= '0;
                    end else begin
                        result_q <= res1;
                        carry_q  <= c1;
                        ovf_q    <= v1;
                        zero_q   <= (res1 == '0);
                        dbz_q    <= dbz1;
                    end
                end
                EXEC: begin
                    opa <= opa_nx;
                    opb <= opb_nx;
                    acc <= acc_nx;
                    cnt <= cnt + SHW'(1);
                    // the last iteration's value is registered directly so the
                    // result is presented WIDTH+1 cycles after accept
                    if (last_iter) begin
                        result_q <= fin_res;
                        carry_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= (fin_res == '0);
                        dbz_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.result      = result_q;
    assign bus.carry_out   = carry_q;
    assign bus.overflow    = ovf_q;
    assign bus.zero_flag   = zero_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_multicycle_param.sv
// Directed bench for alu_multicycle_param, WIDTH=32 and WIDTH=8 instances side by side.
// Flags are compared as {carry_out, overflow, zero_flag, div_by_zero}.
module tb_alu_multicycle_param;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MUL = 4'h2, MOD = 4'h3, DIV = 4'h4,
                           INC = 4'h5, DEC = 4'h6, AND = 4'h7, OR = 4'h8, NOR = 4'h9,
                           XOR = 4'hA, NAND = 4'hB, NOT = 4'hC, SRL = 4'hD, SLL = 4'hE,
                           XNOR = 4'hF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_multicycle_param_if #(.WIDTH(32)) b32 ();
    alu_multicycle_param_if #(.WIDTH(8))  b8 ();

    alu_multicycle_param #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    alu_multicycle_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          w8;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    function automatic vec_t mk(bit w8, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] r, logic [3:0] f, int lat);
        vec_t v;
        v.w8 = w8; v.op = op; v.a = a; v.b = b; v.r = r; v.f = f; v.lat = lat;
        return v;
    endfunction

    // Issue one op and wait (bounded) for out_valid. lat counts cycles from the
    // accept edge; leak records in_ready seen high while the op was in flight.
    // Operands are inverted right after accept to show they were captured.
    task automatic run_op(input bit w8, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output bit leak);
        bit seen;
        @(negedge clk);
        if (w8) begin b8.A = a[7:0]; b8.B = b[7:0]; b8.opcode = op; b8.in_valid = 1'b1; end
        else    begin b32.A = a;     b32.B = b;     b32.opcode = op; b32.in_valid = 1'b1; end
        @(posedge clk);
        lat = 0; leak = 1'b0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                b8.in_valid = 1'b0;  b8.A = ~b8.A;   b8.B = ~b8.B;
                b32.in_valid = 1'b0; b32.A = ~b32.A; b32.B = ~b32.B;
            end
            seen = w8 ? b8.out_valid : b32.out_valid;
            if (!seen && (w8 ? b8.in_ready : b32.in_ready)) leak = 1'b1;
        end
    endtask

    task automatic get(input bit w8, output logic [31:0] r, output logic [3:0] f);
        if (w8) begin
            r = {24'h0, b8.result};
            f = {b8.carry_out, b8.overflow, b8.zero_flag, b8.div_by_zero};
        end else begin
            r = b32.result;
            f = {b32.carry_out, b32.overflow, b32.zero_flag, b32.div_by_zero};
        end
    endtask

    task automatic retire(input bit w8);
        if (w8) b8.out_ready = 1'b1; else b32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b8.out_ready = 1'b0;
        b32.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.A = '0; b32.B = '0; b32.opcode = '0;
        b8.in_valid = 1'b0;  b8.out_ready = 1'b0;  b8.A = '0;  b8.B = '0;  b8.opcode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({b32.in_ready, b32.out_valid, b32.result, b32.carry_out, b32.overflow,
             b32.zero_flag, b32.div_by_zero} !== {2'b10, 32'h0, 4'b0000}) begin
            n_err++;
            $display("FAIL reset32: rdy=%b vld=%b res=%h, want rdy=1 vld=0 res=0 flags=0",
                     b32.in_ready, b32.out_valid, b32.result);
        end
        n_cmp++;
        if ({b8.in_ready, b8.out_valid, b8.result, b8.carry_out, b8.overflow,
             b8.zero_flag, b8.div_by_zero} !== {2'b10, 8'h0, 4'b0000}) begin
            n_err++;
            $display("FAIL reset8: rdy=%b vld=%b res=%h, want rdy=1 vld=0 res=0 flags=0",
                     b8.in_ready, b8.out_valid, b8.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_addsub();
        vec_t v[$];
        int lat; bit leak; logic [31:0] r; logic [3:0] f;
        v.push_back(mk(0, ADD, 32'hFFFFFFFF, 32'h1, 32'h0,        4'b1010, 1));
        v.push_back(mk(0, SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0100, 1));
        v.push_back(mk(0, SUB, 32'h3,        32'h5, 32'hFFFFFFFE, 4'b1000, 1));
        v.push_back(mk(0, INC, 32'h7FFFFFFF, 32'h0, 32'h80000000, 4'b0100, 1));
        v.push_back(mk(0, DEC, 32'h0,        32'h0, 32'hFFFFFFFF, 4'b1000, 1));
        v.push_back(mk(1, ADD, 32'hFF,       32'h1, 32'h0,        4'b1010, 1));
        v.push_back(mk(1, ADD, 32'h7F,       32'h1, 32'h80,       4'b0100, 1));
        v.push_back(mk(1, SUB, 32'h80,       32'h1, 32'h7F,       4'b0100, 1));
        v.push_back(mk(1, SUB, 32'h3,        32'h5, 32'hFE,       4'b1000, 1));
        foreach (v[i]) begin
            run_op(v[i].w8, v[i].op, v[i].a, v[i].b, lat, leak);
            get(v[i].w8, r, f);
            n_cmp++;
            if (r !== v[i].r || f !== v[i].f || lat != v[i].lat || leak) begin
                n_err++;
                $display("FAIL addsub[%0d]: res=%h flags=%b lat=%0d leak=%b, want res=%h flags=%b lat=%0d leak=0",
                         i, r, f, lat, leak, v[i].r, v[i].f, v[i].lat);
            end
            retire(v[i].w8);
        end
    endtask

    task automatic test_mul();
        vec_t v[$];
        int lat; bit leak; logic [31:0] r; logic [3:0] f;
        v.push_back(mk(0, MUL, 32'h7,        32'h6,        32'd42,       4'b0000, 33));
        v.push_back(mk(0, MUL, 32'h10000,    32'h10000,    32'h0,        4'b0010, 33));
        v.push_back(mk(0, MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4'b0000, 33));
        v.push_back(mk(0, MUL, 32'h12345,    32'h100,      32'h01234500, 4'b0000, 33));
        v.push_back(mk(1, MUL, 32'h7,        32'h6,        32'd42,       4'b0000, 9));
        v.push_back(mk(1, MUL, 32'h10,       32'h10,       32'h0,        4'b0010, 9));
        foreach (v[i]) begin
            run_op(v[i].w8, v[i].op, v[i].a, v[i].b, lat, leak);
            get(v[i].w8, r, f);
            n_cmp++;
            if (r !== v[i].r || f !== v[i].f || lat != v[i].lat || leak) begin
                n_err++;
                $display("FAIL mul[%0d]: res=%h flags=%b lat=%0d leak=%b, want res=%h flags=%b lat=%0d leak=0",
                         i, r, f, lat, leak, v[i].r, v[i].f, v[i].lat);
            end
            retire(v[i].w8);
        end
    endtask

    task automatic test_divmod();
        vec_t v[$];
        int lat; bit leak; logic [31:0] r; logic [3:0] f;
        v.push_back(mk(0, DIV, 32'd100,      32'd7,        32'd14,       4'b0000, 33));
        v.push_back(mk(0, MOD, 32'd100,      32'd7,        32'd2,        4'b0000, 33));
        v.push_back(mk(0, DIV, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0001, 1));
        v.push_back(mk(0, MOD, 32'd5,        32'd0,        32'd5,        4'b0001, 1));
        v.push_back(mk(0, DIV, 32'hFFFFFFFF, 32'h10000,    32'hFFFF,     4'b0000, 33));
        v.push_back(mk(0, MOD, 32'hFFFFFFFF, 32'd10,       32'd5,        4'b0000, 33));
        v.push_back(mk(0, DIV, 32'd3,        32'd7,        32'd0,        4'b0010, 33));
        v.push_back(mk(1, DIV, 32'd100,      32'd7,        32'd14,       4'b0000, 9));
        v.push_back(mk(1, MOD, 32'd100,      32'd7,        32'd2,        4'b0000, 9));
        v.push_back(mk(1, DIV, 32'd5,        32'd0,        32'hFF,       4'b0001, 1));
        v.push_back(mk(1, DIV, 32'hFF,       32'h10,       32'h0F,       4'b0000, 9));
        foreach (v[i]) begin
            run_op(v[i].w8, v[i].op, v[i].a, v[i].b, lat, leak);
            get(v[i].w8, r, f);
            n_cmp++;
            if (r !== v[i].r || f !== v[i].f || lat != v[i].lat || leak) begin
                n_err++;
                $display("FAIL divmod[%0d]: res=%h flags=%b lat=%0d leak=%b, want res=%h flags=%b lat=%0d leak=0",
                         i, r, f, lat, leak, v[i].r, v[i].f, v[i].lat);
            end
            retire(v[i].w8);
        end
    endtask

    task automatic test_logic();
        vec_t v[$];
        int lat; bit leak; logic [31:0] r; logic [3:0] f;
        v.push_back(mk(0, AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0000, 1));
        v.push_back(mk(0, OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b0000, 1));
        v.push_back(mk(0, XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 1));
        v.push_back(mk(0, XNOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 4'b0000, 1));
        v.push_back(mk(0, NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 4'b0000, 1));
        v.push_back(mk(0, NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        4'b0010, 1));
        v.push_back(mk(0, NOT,  32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 4'b0000, 1));
        v.push_back(mk(0, SLL,  32'h1,        32'd31,       32'h80000000, 4'b0000, 1));
        v.push_back(mk(0, SRL,  32'h80000000, 32'h21,       32'h40000000, 4'b0000, 1));
        v.push_back(mk(1, SLL,  32'h0F,       32'd4,        32'hF0,       4'b0000, 1));
        v.push_back(mk(1, SRL,  32'h80,       32'd7,        32'h01,       4'b0000, 1));
        foreach (v[i]) begin
            run_op(v[i].w8, v[i].op, v[i].a, v[i].b, lat, leak);
            get(v[i].w8, r, f);
            n_cmp++;
            if (r !== v[i].r || f !== v[i].f || lat != v[i].lat || leak) begin
                n_err++;
                $display("FAIL logic[%0d]: res=%h flags=%b lat=%0d leak=%b, want res=%h flags=%b lat=%0d leak=0",
                         i, r, f, lat, leak, v[i].r, v[i].f, v[i].lat);
            end
            retire(v[i].w8);
        end
    endtask

    task automatic test_hold();
        int lat; bit leak; bit unstable;
        logic [31:0] r, r0; logic [3:0] f, f0;
        run_op(0, DIV, 32'd1000, 32'd10, lat, leak);
        get(0, r0, f0);
        n_cmp++;
        if (r0 !== 32'd100 || f0 !== 4'b0000 || lat != 33) begin
            n_err++;
            $display("FAIL hold_div: res=%h flags=%b lat=%0d, want res=00000064 flags=0000 lat=33", r0, f0, lat);
        end
        unstable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            get(0, r, f);
            if (r !== r0 || f !== f0 || b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0) unstable = 1'b1;
        end
        n_cmp++;
        if (unstable) begin
            n_err++;
            $display("FAIL hold_stable: unstable=%b, want 0", unstable);
        end
        retire(0);
        n_cmp++;
        if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_retire: rdy=%b vld=%b, want rdy=1 vld=0", b32.in_ready, b32.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit leak; bit spurious;
        logic [31:0] r; logic [3:0] f;
        @(negedge clk);
        b32.A = 32'd1000; b32.B = 32'd7; b32.opcode = DIV; b32.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        get(0, r, f);
        n_cmp++;
        if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || r !== 32'h0 || f !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid: vld=%b rdy=%b res=%h flags=%b, want vld=0 rdy=1 res=0 flags=0000",
                     b32.out_valid, b32.in_ready, r, f);
        end
        spurious = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (b32.out_valid !== 1'b0) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious) begin
            n_err++;
            $display("FAIL rst_discard: out_valid seen=%b, want 0", spurious);
        end
        run_op(0, ADD, 32'd2, 32'd3, lat, leak);
        get(0, r, f);
        n_cmp++;
        if (r !== 32'd5 || f !== 4'b0000 || lat != 1) begin
            n_err++;
            $display("FAIL rst_add: res=%h flags=%b lat=%0d, want res=00000005 flags=0000 lat=1", r, f, lat);
        end
        retire(0);
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_divmod();
        test_logic();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2000000");
        $fatal(1);
    end
endmodule
